// File: rtl/s38584_g283_pkg.sv
// Shared definitions for the g283 scheduler: cone-input bit map and the request record
// carried through the first pipeline stage.
package s38584_g283_pkg;

  localparam int VEC_W = 25;

  localparam int G35  = 0;
  localparam int G287 = 1;
  localparam int G278 = 2;
  localparam int G691 = 3;
  localparam int G255 = 4;
  localparam int G232 = 5;
  localparam int G225 = 6;
  localparam int G269 = 7;
  localparam int G239 = 8;
  localparam int G246 = 9;
  localparam int G262 = 10;
  localparam int G655 = 11;
  localparam int G753 = 12;
  localparam int G718 = 13;
  localparam int G554 = 14;
  localparam int G807 = 15;
  localparam int G482 = 16;
  localparam int G528 = 17;
  localparam int G490 = 18;
  localparam int G499 = 19;
  localparam int G518 = 20;
  localparam int G376 = 21;
  localparam int G370 = 22;
  localparam int G358 = 23;
  localparam int G385 = 24;

  typedef struct packed {
    logic             src;
    logic [VEC_W-1:0] vec;
    logic             load;
    logic             load_val;
  } req_t;

endpackage

// File: rtl/s38584_g283_cone.sv
// Next-state cone of g283: f(vec, s). Purely combinational.
module s38584_g283_cone
  import s38584_g283_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  input  logic             s,
  output logic             f
);

  logic t0, t1, t2, t3, k, p, q, x;

  always_comb begin
    t0 = ~vec[G655] & ~vec[G753] & ~vec[G718];
    t1 = vec[G482] | vec[G528] | vec[G490] | vec[G499] | vec[G518];
    t2 = ~(vec[G376] & ~vec[G370] & vec[G358] & vec[G385]);
    t3 = ~(vec[G655] & vec[G753] & vec[G718] & (~vec[G554] | ~vec[G807]));
    k  = ~(t0 | t1 | t2 | t3);
    p  = vec[G255] | ~vec[G232] | ~vec[G225]
       | ~(~vec[G269] & vec[G239] & vec[G246] & ~vec[G262]);
    q  = ~(vec[G255] & ~vec[G232] & ~vec[G225] & vec[G269]
         & ~vec[G239] & ~vec[G246] & vec[G262]);
    x  = k | ~vec[G691] | (vec[G278] ? p : q);
    // g35 low means the register simply holds.
    f  = vec[G35] ? (~x & (s ^ vec[G287])) : s;
  end

endmodule

// File: rtl/s38584_g283_sched.sv
// g283 owner: arbitrates two requesters into a 2-stage pipeline, evaluates the cone
// against the live register in stage 2, supports scan-load and counts toggles.
module s38584_g283_sched
  import s38584_g283_pkg::*;
#(
  parameter int   CNT_W     = 16,
  parameter logic RST_STATE = 1'b0,
  parameter bit   FIXED_PRI = 1'b0
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [VEC_W-1:0] req0_vec,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [VEC_W-1:0] req1_vec,
  input  logic             req1_load,
  input  logic             req1_load_val,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_src,
  output logic             resp_q,
  output logic             state_q,
  output logic [CNT_W-1:0] tgl_cnt,
  output logic             busy
);

  // Handshake: a transfer happens on an edge where valid and ready are both high;
  // ready is combinational from the same-cycle valids and pipeline occupancy.

  req_t             s1_req, in_req;
  logic             s1_valid, s2_valid, s2_src, s2_q;
  logic             g283, rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             stall, s2_take, grant_en, pick1, gnt0, gnt1;
  logic             cone_out, next_s;

  // A stalled stage 2 freezes everything upstream, so grants are withheld too.
  assign stall    = s2_valid & ~resp_ready;
  assign s2_take  = s1_valid & ~stall;
  assign grant_en = ~RST & ~stall;

  always_comb begin
    pick1 = req1_valid;
    if (req0_valid & req1_valid) pick1 = FIXED_PRI ? 1'b1 : rr_ptr;
  end

  assign gnt0 = grant_en & req0_valid & ~pick1;
  assign gnt1 = grant_en & req1_valid & pick1;

  always_comb begin
    in_req          = '0;
    in_req.src      = pick1;
    in_req.vec      = pick1 ? req1_vec : req0_vec;
    in_req.load     = pick1 & req1_load;
    in_req.load_val = pick1 & req1_load_val;
  end

  s38584_g283_cone u_cone (
    .vec (s1_req.vec),
    .s   (g283),
    .f   (cone_out)
  );

  assign next_s = s1_req.load ? s1_req.load_val : cone_out;

  always_ff @(posedge CK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s2_valid <= 1'b0;
      s2_src   <= 1'b0;
      s2_q     <= 1'b0;
      g283     <= RST_STATE;
      rr_ptr   <= 1'b0;
      cnt      <= '0;
    end else begin
      if (gnt0 | gnt1) begin
        s1_valid <= 1'b1;
        s1_req   <= in_req;
      end else if (s2_take) begin
        s1_valid <= 1'b0;
      end

      if (s2_take) begin
        s2_valid <= 1'b1;
        s2_src   <= s1_req.src;
        s2_q     <= next_s;
        g283     <= next_s;
        if ((next_s != g283) && (cnt != '1)) cnt <= cnt + CNT_W'(1);
      end else if (resp_ready) begin
        s2_valid <= 1'b0;
      end

      // Favour the loser of a contested grant next time.
      if (req0_valid & req1_valid & (gnt0 | gnt1)) rr_ptr <= ~pick1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign resp_valid = s2_valid;
  assign resp_src   = s2_src;
  assign resp_q     = s2_q;
  assign state_q    = g283;
  assign tgl_cnt    = cnt;
  assign busy       = s1_valid | s2_valid;

endmodule

// File: tb/tb_s38584_g283_sched.sv
// Directed bench for s38584_g283_sched: hand-computed responses held in an expected queue,
// plus a second instance with a 2-bit counter for saturation.
module tb_s38584_g283_sched;
  import s38584_g283_pkg::*;

  logic             CK = 1'b0;
  logic             RST;
  logic             req0_valid, req1_valid, req1_load, req1_load_val, resp_ready;
  logic [VEC_W-1:0] req0_vec, req1_vec;
  logic             req0_ready, req1_ready, resp_valid, resp_src, resp_q, state_q, busy;
  logic [15:0]      tgl_cnt;
  logic             s_req0_ready, s_req1_ready, s_resp_valid, s_resp_src, s_resp_q;
  logic             s_state_q, s_busy;
  logic [1:0]       s_tgl_cnt;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [1:0] exp_q[$];   // {src, q}
  logic [VEC_W-1:0] v, kv;

  s38584_g283_sched dut (
    .CK(CK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_vec(req0_vec),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_vec(req1_vec),
    .req1_load(req1_load), .req1_load_val(req1_load_val),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_src(resp_src),
    .resp_q(resp_q), .state_q(state_q), .tgl_cnt(tgl_cnt), .busy(busy)
  );

  s38584_g283_sched #(.CNT_W(2)) dut_sat (
    .CK(CK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_vec(req0_vec),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_vec(req1_vec),
    .req1_load(req1_load), .req1_load_val(req1_load_val),
    .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_src(s_resp_src),
    .resp_q(s_resp_q), .state_q(s_state_q), .tgl_cnt(s_tgl_cnt), .busy(s_busy)
  );

  // ---------------- clock ----------------
  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every consumed response must match the head of exp_q.
  always @(negedge CK) begin
    if (!RST && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) check("resp_unexpected", 32'(resp_valid), 32'd0);
      else check("resp", {resp_src, resp_q}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    exp_q.delete();
  endtask

  task automatic issue(input bit src, input logic [VEC_W-1:0] vec, input bit ld, input bit lv,
                       input bit push, input logic [1:0] exp);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    if (src) begin
      req1_valid = 1'b1; req1_vec = vec; req1_load = ld; req1_load_val = lv;
    end else begin
      req0_valid = 1'b1; req0_vec = vec;
    end
    while (!acc && n < 20) begin
      @(negedge CK);
      acc = src ? req1_ready : req0_ready;
      if (acc && push) exp_q.push_back(exp);
      tick();
      n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; req1_load = 1'b0;
    check("issue_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge CK);
    while ((busy || exp_q.size() != 0) && n < 40) begin
      @(negedge CK);
      n++;
    end
    check({tag, "_drain_q"}, exp_q.size(), 0);
    check({tag, "_drain_busy"}, 32'(busy), 32'd0);
    tick();
  endtask

  function automatic logic [VEC_W-1:0] vb();
    logic [VEC_W-1:0] b;
    b = '0;
    b[G35] = 1'b1; b[G691] = 1'b1; b[G255] = 1'b1; b[G269] = 1'b1; b[G262] = 1'b1;
    return b;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    RST = 1'b1; resp_ready = 1'b1;
    req0_vec = '0; req1_vec = '0; req1_load = 1'b0; req1_load_val = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    @(negedge CK);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", {req1_ready, req0_ready}, 32'd0);
    check("rst_state", 32'(state_q), 32'd0);
    check("rst_tgl", tgl_cnt, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; RST = 1'b0;

    // Hold: g35=0 keeps g283; latency N+2.
    v = vb(); v[G287] = 1'b1; v[G35] = 1'b0;
    issue(1'b0, v, 1'b0, 1'b0, 1'b1, 2'b00);
    @(negedge CK); check("t1_lat_n1", 32'(resp_valid), 32'd0);
    tick();
    @(negedge CK); check("t1_lat_n2", 32'(resp_valid), 32'd1);
    drain("t1");
    check("t1_state", 32'(state_q), 32'd0);
    check("t1_tgl", tgl_cnt, 32'd0);

    // Toggle and cone paths.
    v = vb(); v[G287] = 1'b1;
    issue(1'b0, v, 1'b0, 1'b0, 1'b1, 2'b01);
    drain("t2a");
    check("t2a_tgl", tgl_cnt, 32'd1);
    v[G691] = 1'b0;
    issue(1'b0, v, 1'b0, 1'b0, 1'b1, 2'b00);
    drain("t2b");
    check("t2b_tgl", tgl_cnt, 32'd2);
    v = vb(); v[G287] = 1'b1; v[G278] = 1'b1;           // P path forces X=1
    issue(1'b0, v, 1'b0, 1'b0, 1'b1, 2'b00);
    kv = vb(); kv[G287] = 1'b1; kv[G655] = 1'b1; kv[G753] = 1'b1; kv[G718] = 1'b1;
    kv[G376] = 1'b1; kv[G358] = 1'b1; kv[G385] = 1'b1;  // K=1 blocks toggle
    issue(1'b0, kv, 1'b0, 1'b0, 1'b1, 2'b00);
    kv[G554] = 1'b1; kv[G807] = 1'b1;                   // K=0 lets it toggle
    issue(1'b0, kv, 1'b0, 1'b0, 1'b1, 2'b01);
    drain("t2c");
    check("t2c_state", 32'(state_q), 32'd1);
    check("t2c_tgl", tgl_cnt, 32'd3);

    // Round-robin with both requesters valid.
    do_reset();
    v = vb(); v[G287] = 1'b1;
    req0_vec = v; req1_vec = v; req1_load = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CK);
      check("t3_grant", {req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      exp_q.push_back({i[0], ~i[0]});
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t3");
    check("t3_tgl", tgl_cnt, 32'd4);
    check("t3_state", 32'(state_q), 32'd0);

    // Backpressure with two ops in flight and a third waiting.
    do_reset();
    resp_ready = 1'b0;
    v = vb(); v[G287] = 1'b1;
    issue(1'b0, v, 1'b0, 1'b0, 1'b1, 2'b01);
    issue(1'b0, v, 1'b0, 1'b0, 1'b1, 2'b00);
    req0_vec = v; req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      check("t4_hold_valid", 32'(resp_valid), 32'd1);
      check("t4_hold_resp", {resp_src, resp_q}, 32'd1);
      check("t4_no_grant", 32'(req0_ready), 32'd0);
      check("t4_state", 32'(state_q), 32'd1);
      check("t4_busy", 32'(busy), 32'd1);
      tick();
    end
    resp_ready = 1'b1;
    begin
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 10) begin
        @(negedge CK);
        acc = req0_ready;
        if (acc) exp_q.push_back(2'b01);
        tick();
        n++;
      end
      req0_valid = 1'b0;
      check("t4_third_accept", 32'(acc), 32'd1);
    end
    drain("t4");
    check("t4_tgl", tgl_cnt, 32'd3);
    check("t4_end_state", 32'(state_q), 32'd1);

    // Scan-load.
    do_reset();
    issue(1'b1, '0, 1'b1, 1'b1, 1'b1, 2'b11);
    drain("t5a");
    check("t5a_state", 32'(state_q), 32'd1);
    check("t5a_tgl", tgl_cnt, 32'd1);
    issue(1'b1, '0, 1'b1, 1'b1, 1'b1, 2'b11);
    drain("t5b");
    check("t5b_tgl", tgl_cnt, 32'd1);
    issue(1'b1, '0, 1'b1, 1'b0, 1'b1, 2'b10);
    drain("t5c");
    check("t5c_state", 32'(state_q), 32'd0);
    check("t5c_tgl", tgl_cnt, 32'd2);

    // Reset with two ops in flight.
    do_reset();
    resp_ready = 1'b0;
    v = vb(); v[G287] = 1'b1;
    issue(1'b0, v, 1'b0, 1'b0, 1'b0, 2'b00);
    issue(1'b0, v, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge CK);
    check("t6_pre_state", 32'(state_q), 32'd1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    tick();
    RST = 1'b1;
    tick();
    @(negedge CK);
    check("t6_rst_valid", 32'(resp_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_state", 32'(state_q), 32'd0);
    check("t6_rst_tgl", tgl_cnt, 32'd0);
    tick();
    RST = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CK);
      check("t6_no_resp", 32'(resp_valid), 32'd0);
      tick();
    end

    // Saturation of the 2-bit instance after five toggles.
    for (int i = 0; i < 5; i++) issue(1'b0, v, 1'b0, 1'b0, 1'b1, {1'b0, ~i[0]});
    drain("t6s");
    check("t6_sat_tgl", s_tgl_cnt, 32'd3);
    check("t6_wide_tgl", tgl_cnt, 32'd5);
    check("t6_sat_state", 32'(s_state_q), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
